gates_mux_selftest: RTL and testbench

//  Sequential stimulus/checker wrapped around the 2-input mux-built gate set.
//  On start, it drives all four (s,b) vectors into the gate block.
//  It captures the seven gate outputs per vector into a 28-bit truth table.
//  It then compares the table against the golden AND/OR/BUF/NAND/NOR/XOR/XNOR

---
 rtl/gates_mux_selftest.sv | 155 +++++++++++++++
 tb/tb_gates_mux_selftest.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gates_mux_selftest.sv
// Built-in self-test sequencer for the 2-input mux-built gate set.
// It walks the four {s,b} vectors, captures all seven gate outputs into a
// 28-bit truth table, then compares each gate nibble against its golden table.
// Optional feature: define ERR_CNT_EN to add the saturating err_cnt output.
module gates_mux_selftest #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  gate_y,
  output logic        s_out,
  output logic        b_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [6:0]  fail_mask,
  output logic [27:0] tt
`ifdef ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    CHECK
  } state_e;

  // Golden nibble per gate, bit v = response to vector v={s,b}.
  localparam logic [6:0][3:0] GOLDEN = {4'h9, 4'h6, 4'h1, 4'h7, 4'hC, 4'hE, 4'h8};
  localparam logic [3:0]      CNT_INIT = 4'(SETTLE_CYC - 1);

  state_e          state_q, state_d;
  logic [1:0]      v_q, v_d;
  logic [1:0]      vec_q, vec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [6:0]      mask_q, mask_d;
  logic [6:0][3:0] tt_q, tt_d;
`ifdef ERR_CNT_EN
  logic [7:0]      err_q, err_d;
`endif

  // Next-state and next-output computation for the test sequencer.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mask_d  = mask_q;
    tt_d    = tt_q;
`ifdef ERR_CNT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          v_d     = 2'd0;
          vec_d   = 2'b00;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          mask_d  = '0;
          cnt_d   = CNT_INIT;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        for (int unsigned g = 0; g < 7; g++) begin
          tt_d[g][v_q] = gate_y[g];
        end
        if (v_q == 2'd3) begin
          state_d = CHECK;
        end else begin
          v_d     = v_q + 2'd1;
          vec_d   = v_q + 2'd1;
          cnt_d   = CNT_INIT;
          state_d = DRIVE;
        end
      end
      CHECK: begin
        for (int unsigned g = 0; g < 7; g++) begin
          mask_d[g] = (tt_q[g] != GOLDEN[g]);
        end
        pass_d  = (mask_d == '0);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef ERR_CNT_EN
        if ((mask_d != '0) && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset returns everything to zero at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      tt_q    <= '0;
`ifdef ERR_CNT_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      tt_q    <= tt_d;
`ifdef ERR_CNT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign s_out     = vec_q[1];
  assign b_out     = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;
  assign tt        = tt_q;
`ifdef ERR_CNT_EN
  assign err_cnt   = err_q;
`endif

endmodule

// File: tb/tb_gates_mux_selftest.sv
// Scoreboard bench for gates_mux_selftest with a faultable gate-block model.
module tb_gates_mux_selftest;

  localparam int unsigned SETTLE = 1;
  localparam int LAT = 4 * (SETTLE + 1) + 1;

  typedef struct {
    logic [27:0] tt;
    logic [6:0]  mask;
    logic        pass;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  gate_y;
  logic        s_out, b_out, busy, done, pass;
  logic [6:0]  fail_mask;
  logic [27:0] tt;
`ifdef ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   mode = 0;
  int   last_vec = -1;
  int   obs[$];
  exp_t sbq[$];

  gates_mux_selftest #(.SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_y(gate_y),
    .s_out(s_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .tt(tt)
`ifdef ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate block model: 0 good, 1 ya stuck-1, 2 yxo wired to yxn, 3 yo stuck-0, 4 all stuck-0.
  always_comb begin
    logic ya, yo, yn, yna, yno, yxo, yxn;
    ya  = s_out & b_out;
    yo  = s_out | b_out;
    yn  = s_out;
    yna = ~(s_out & b_out);
    yno = ~(s_out | b_out);
    yxo = s_out ^ b_out;
    yxn = ~(s_out ^ b_out);
    case (mode)
      1: ya = 1'b1;
      2: yxo = yxn;
      3: yo = 1'b0;
      default: ;
    endcase
    gate_y = {yxn, yxo, yno, yna, yn, yo, ya};
    if (mode == 4) gate_y = '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("tt", 32'(tt), 32'(e.tt));
        chk("fail_mask", 32'(fail_mask), 32'(e.mask));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("done_cycle", 32'(cyc), 32'(e.due));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Records each distinct vector driven during a run.
  always @(negedge clk) begin
    if (busy === 1'b1 && int'({s_out, b_out}) != last_vec) begin
      last_vec = int'({s_out, b_out});
      obs.push_back(last_vec);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic expect_run(input logic [27:0] t, input logic [6:0] m, input logic p, input int due);
    exp_t e;
    e.tt = t; e.mask = m; e.pass = p; e.due = due;
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || busy === 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("run_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_one(input int m, input logic [27:0] t, input logic [6:0] mk, input logic p);
    mode = m;
    pulse_start();
    expect_run(t, mk, p, cyc + LAT);
    wait_idle();
  endtask

  initial begin
    int dc0, e0;
    repeat (3) @(negedge clk);
    chk("rst_s_out", 32'(s_out), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_mask", 32'(fail_mask), 32'd0);
    chk("rst_tt", 32'(tt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed runs with hand-computed tables.
    run_one(0, 28'h9617CE8, 7'b0000000, 1'b1);
    run_one(1, 28'h9617CEF, 7'b0000001, 1'b0);
    repeat (3) @(negedge clk);
    chk("pass_hold", 32'(pass), 32'd0);
    chk("mask_hold", 32'(fail_mask), 32'd1);
    chk("tt_hold", 32'(tt), 32'h9617CEF);
    run_one(2, 28'h9917CE8, 7'b0100000, 1'b0);
    run_one(3, 28'h9617C08, 7'b0000010, 1'b0);
    run_one(4, 28'h0000000, 7'b1111111, 1'b0);

    // Start pulses while busy are ignored; vectors step once.
    mode = 0;
    obs.delete();
    last_vec = -1;
    dc0 = done_cnt;
    pulse_start();
    expect_run(28'h9617CE8, 7'b0, 1'b1, cyc + LAT);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("single_done", 32'(done_cnt - dc0), 32'd1);
    chk("vec_count", 32'(obs.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs.size(); i++) chk("vec_seq", 32'(obs[i]), 32'(i));

    // Back-to-back: start held in the done cycle is accepted.
    dc0 = done_cnt;
    mode = 1;
    pulse_start();
    e0 = cyc;
    expect_run(28'h9617CEF, 7'b0000001, 1'b0, e0 + LAT);
    repeat (LAT) @(negedge clk);
    chk("b2b_done_seen", 32'(done), 32'd1);
    mode = 0;
    start = 1'b1;
    expect_run(28'h9617CE8, 7'b0, 1'b1, cyc + 1 + LAT);
    @(negedge clk) start = 1'b0;
    wait_idle();
    chk("b2b_done_count", 32'(done_cnt - dc0), 32'd2);

    // Reset mid-run: immediate clear, no done, no restart.
    mode = 0;
    pulse_start();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_s_out", 32'(s_out), 32'd0);
    chk("mrst_b_out", 32'(b_out), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_tt", 32'(tt), 32'd0);
    chk("mrst_pass", 32'(pass), 32'd0);
    dc0 = done_cnt;
    @(negedge clk) rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("mrst_no_done", 32'(done_cnt - dc0), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);

`ifdef ERR_CNT_EN
    chk("errcnt_rst", 32'(err_cnt), 32'd0);
    run_one(0, 28'h9617CE8, 7'b0, 1'b1);
    chk("errcnt_pass_run", 32'(err_cnt), 32'd0);
    for (int r = 0; r < 300; r++) run_one(1, 28'h9617CEF, 7'b0000001, 1'b0);
    chk("errcnt_sat", 32'(err_cnt), 32'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
